// File: rtl/specialreg_bank_pkg.sv
// Shared constants and types for the Elpis special-register (RM) bank.
//   PC_INITIAL    : reset value of rm0 (EPC)
//   RM_*          : fixed indices of the architected special registers
//   PSW_PRIV_BIT  : PSW bit that marks privileged (exception) mode
//   rm_event_e    : the single event the bank acts on in a given cycle
//   decode_event  : resolves simultaneous requests by priority
package specialreg_bank_pkg;

    localparam logic [31:0] PC_INITIAL   = 32'h0000_2000;

    localparam int          RM_EPC       = 0;
    localparam int          RM_ADDR      = 1;
    localparam int          RM_CAUSE     = 2;
    localparam int          RM_PSW       = 3;
    localparam int          RM_IO        = 4;
    localparam int          PSW_PRIV_BIT = 0;

    typedef enum logic [2:0] {
        EV_IDLE,
        EV_RESET,
        EV_EXC,
        EV_IRET,
        EV_WRITE
    } rm_event_e;

    // Only the highest-priority request survives; the rest are dropped
    // without any side effect.
    function automatic rm_event_e decode_event(input logic reset,
                                               input logic exc_valid,
                                               input logic iret,
                                               input logic we);
        if (reset)          return EV_RESET;
        else if (exc_valid) return EV_EXC;
        else if (iret)      return EV_IRET;
        else if (we)        return EV_WRITE;
        else                return EV_IDLE;
    endfunction

endpackage

// File: rtl/specialreg_stack.sv
// LIFO shadow stack holding saved {rm0, rm1, rm2, rm3} contexts.
//   clk, reset : falling-edge clock, synchronous active-high reset
//   push, pop  : push has priority; push when full / pop when empty are ignored
//   din        : context to save
//   dout       : top entry (don't care while empty)
//   count      : current occupancy, saturates at DEPTH
//   full/empty : occupancy flags
module specialreg_stack #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [0:(1<<IW)-1];
    logic [CW-1:0]    top_cnt;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Next free slot is mem[count]; the top entry sits one below it.
    assign top_cnt = count - CW'(1);
    assign wr_idx  = count[IW-1:0];
    assign rd_idx  = top_cnt[IW-1:0];
    assign dout    = mem[rd_idx];

    // Contents are not cleared on reset: count alone defines what is valid.
    always_ff @(negedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= din;
            count       <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= top_cnt;
        end
    end

endmodule

// File: rtl/specialreg_bank.sv
// Special-register (RM) bank of the Elpis core with nested-exception support.
//   clk, reset          : falling-edge clock, synchronous active-high reset
//   exc_valid           : exception commit; loads exc_pc/exc_addr/exc_cause, psw=1
//   iret                : return from exception; pops the shadow stack if non-empty
//   we, wsel, wdata     : software RM write (out-of-range wsel ignored)
//   rsel, rdata         : combinational read port (0 for out-of-range rsel)
//   out_rm0/1/2, out_psw, out_rm4 : direct views of rm0..rm4
//   depth               : shadow-stack occupancy
//   overflow            : sticky, set when a nested exception finds the stack full
module specialreg_bank
    import specialreg_bank_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               NUM_RM      = 5,
    parameter int               STACK_DEPTH = 4,
    parameter logic [XLEN-1:0]  RST_PC      = XLEN'(PC_INITIAL)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             exc_valid,
    input  logic [XLEN-1:0]                  exc_pc,
    input  logic [XLEN-1:0]                  exc_addr,
    input  logic [XLEN-1:0]                  exc_cause,
    input  logic                             iret,
    input  logic                             we,
    input  logic [$clog2(NUM_RM)-1:0]        wsel,
    input  logic [XLEN-1:0]                  wdata,
    input  logic [$clog2(NUM_RM)-1:0]        rsel,
    output logic [XLEN-1:0]                  rdata,
    output logic [XLEN-1:0]                  out_rm0,
    output logic [XLEN-1:0]                  out_rm1,
    output logic [XLEN-1:0]                  out_rm2,
    output logic [XLEN-1:0]                  out_psw,
    output logic [XLEN-1:0]                  out_rm4,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             overflow
);

    localparam int SW = $clog2(NUM_RM);

    logic [XLEN-1:0]   rm [NUM_RM];
    rm_event_e         ev;
    logic              priv;
    logic              wr_ok;
    logic              rd_ok;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_full;
    logic              stk_empty;
    logic [4*XLEN-1:0] stk_din;
    logic [4*XLEN-1:0] stk_dout;

    assign ev    = decode_event(reset, exc_valid, iret, we);
    assign priv  = rm[RM_PSW][PSW_PRIV_BIT];
    assign wr_ok = ({1'b0, wsel} < (SW+1)'(NUM_RM));
    assign rd_ok = ({1'b0, rsel} < (SW+1)'(NUM_RM));

    // A nested exception saves the outer context on the same edge that the
    // new one is loaded; with the stack full the outer context is simply lost.
    assign stk_push = (ev == EV_EXC) && priv && !stk_full;
    assign stk_pop  = (ev == EV_IRET) && !stk_empty;
    assign stk_din  = {rm[RM_EPC], rm[RM_ADDR], rm[RM_CAUSE], rm[RM_PSW]};

    specialreg_stack #(
        .WIDTH (4*XLEN),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .dout  (stk_dout),
        .count (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(negedge clk) begin
        unique case (ev)
            EV_RESET: begin
                for (int i = 0; i < NUM_RM; i++) rm[i] <= '0;
                rm[RM_EPC] <= RST_PC;
                overflow   <= 1'b0;
            end
            EV_EXC: begin
                rm[RM_EPC]   <= exc_pc;
                rm[RM_ADDR]  <= exc_addr;
                rm[RM_CAUSE] <= exc_cause;
                rm[RM_PSW]   <= XLEN'(1);
                if (priv && stk_full) overflow <= 1'b1;
            end
            EV_IRET: begin
                if (!stk_empty) begin
                    {rm[RM_EPC], rm[RM_ADDR], rm[RM_CAUSE], rm[RM_PSW]} <= stk_dout;
                end else begin
                    // Outermost return: drop to user mode, EPC/addr stay readable.
                    rm[RM_CAUSE] <= '0;
                    rm[RM_PSW]   <= '0;
                end
            end
            EV_WRITE: begin
                if (wr_ok) rm[wsel] <= wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (rd_ok) rdata = rm[rsel];
    end

    assign out_rm0 = rm[RM_EPC];
    assign out_rm1 = rm[RM_ADDR];
    assign out_rm2 = rm[RM_CAUSE];
    assign out_psw = rm[RM_PSW];
    assign out_rm4 = rm[RM_IO];

endmodule

// File: tb/tb_specialreg_bank.sv
// Bench for specialreg_bank: a default instance (STACK_DEPTH=4) and a
// shallow one (STACK_DEPTH=2) share all inputs; a reference model of the
// register rules tracks both.
module tb_specialreg_bank;
    import specialreg_bank_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_pc = '0;
    logic [31:0] exc_addr = '0;
    logic [31:0] exc_cause = '0;
    logic        iret = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  wsel = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  rsel = '0;

    logic [31:0] a_rdata, a_rm0, a_rm1, a_rm2, a_psw, a_rm4;
    logic [2:0]  a_depth;
    logic        a_ovf;
    logic [31:0] b_rdata, b_rm0, b_rm1, b_rm2, b_psw, b_rm4;
    logic [1:0]  b_depth;
    logic        b_ovf;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: index 0 = default instance, 1 = STACK_DEPTH=2 instance.
    logic [31:0] m_rm  [2][5];
    logic [31:0] m_stk [2][4][4];
    int          m_dep [2];
    logic        m_ovf [2];
    int          m_lim [2] = '{4, 2};

    always #5 clk = ~clk;

    specialreg_bank dut (
        .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_pc(exc_pc),
        .exc_addr(exc_addr), .exc_cause(exc_cause), .iret(iret), .we(we),
        .wsel(wsel), .wdata(wdata), .rsel(rsel), .rdata(a_rdata),
        .out_rm0(a_rm0), .out_rm1(a_rm1), .out_rm2(a_rm2), .out_psw(a_psw),
        .out_rm4(a_rm4), .depth(a_depth), .overflow(a_ovf)
    );

    specialreg_bank #(.STACK_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_pc(exc_pc),
        .exc_addr(exc_addr), .exc_cause(exc_cause), .iret(iret), .we(we),
        .wsel(wsel), .wdata(wdata), .rsel(rsel), .rdata(b_rdata),
        .out_rm0(b_rm0), .out_rm1(b_rm1), .out_rm2(b_rm2), .out_psw(b_psw),
        .out_rm4(b_rm4), .depth(b_depth), .overflow(b_ovf)
    );

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int j = 0; j < 5; j++) m_rm[k][j] = '0;
                m_rm[k][0] = PC_INITIAL;
                m_dep[k] = 0;
                m_ovf[k] = 1'b0;
            end else if (exc_valid) begin
                if (m_rm[k][3][0]) begin
                    if (m_dep[k] < m_lim[k]) begin
                        for (int j = 0; j < 4; j++) m_stk[k][m_dep[k]][j] = m_rm[k][j];
                        m_dep[k]++;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end
                m_rm[k][0] = exc_pc;
                m_rm[k][1] = exc_addr;
                m_rm[k][2] = exc_cause;
                m_rm[k][3] = 32'd1;
            end else if (iret) begin
                if (m_dep[k] > 0) begin
                    m_dep[k]--;
                    for (int j = 0; j < 4; j++) m_rm[k][j] = m_stk[k][m_dep[k]][j];
                end else begin
                    m_rm[k][2] = '0;
                    m_rm[k][3] = '0;
                end
            end else if (we && wsel < 3'd5) begin
                m_rm[k][wsel] = wdata;
            end
        end
    endtask

    // Present one cycle of inputs, let the falling edge act, then sample
    // just after the following rising edge.
    task automatic step(input logic r, input logic e, input logic [31:0] pc,
                        input logic [31:0] addr, input logic [31:0] cause,
                        input logic ir, input logic w, input logic [2:0] ws,
                        input logic [31:0] wd);
        reset = r; exc_valid = e; exc_pc = pc; exc_addr = addr; exc_cause = cause;
        iret = ir; we = w; wsel = ws; wdata = wd;
        model_step();
        @(negedge clk);
        @(posedge clk);
        reset = 1'b0; exc_valid = 1'b0; iret = 1'b0; we = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_exc(input logic [31:0] pc, input logic [31:0] addr,
                          input logic [31:0] cause);
        step(0, 1, pc, addr, cause, 0, 0, 0, 0);
    endtask

    task automatic do_iret();
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rsel = 3'(i);
            #1;
            exp = (i == 0) ? PC_INITIAL : 32'd0;
            n_cmp++;
            if (a_rdata !== exp) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h expected %h", i, a_rdata, exp);
            end
        end
        n_cmp++;
        if (a_depth !== 3'd0) begin n_fail++; $display("FAIL reset_depth: got %0d expected 0", a_depth); end
        n_cmp++;
        if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", a_ovf); end
    endtask

    task automatic test_user_mode();
        do_reset();
        do_exc(32'h100, 32'hBEEF, 32'd2);
        n_cmp++;
        if (a_rm0 !== 32'h100) begin n_fail++; $display("FAIL user_rm0: got %h expected 100", a_rm0); end
        n_cmp++;
        if (a_rm1 !== 32'hBEEF) begin n_fail++; $display("FAIL user_rm1: got %h expected beef", a_rm1); end
        n_cmp++;
        if (a_rm2 !== 32'd2) begin n_fail++; $display("FAIL user_rm2: got %h expected 2", a_rm2); end
        n_cmp++;
        if (a_psw !== 32'd1) begin n_fail++; $display("FAIL user_psw: got %h expected 1", a_psw); end
        n_cmp++;
        if (a_depth !== 3'd0) begin n_fail++; $display("FAIL user_depth: got %0d expected 0", a_depth); end
        do_iret();
        n_cmp++;
        if (a_rm2 !== 32'd0) begin n_fail++; $display("FAIL user_iret_rm2: got %h expected 0", a_rm2); end
        n_cmp++;
        if (a_psw !== 32'd0) begin n_fail++; $display("FAIL user_iret_psw: got %h expected 0", a_psw); end
        n_cmp++;
        if (a_rm0 !== 32'h100) begin n_fail++; $display("FAIL user_iret_rm0: got %h expected 100", a_rm0); end
        n_cmp++;
        if (a_rm1 !== 32'hBEEF) begin n_fail++; $display("FAIL user_iret_rm1: got %h expected beef", a_rm1); end
    endtask

    task automatic test_nesting();
        do_reset();
        do_exc(32'h10, 32'hA10, 32'd1);
        do_exc(32'h20, 32'hA20, 32'd2);
        do_exc(32'h30, 32'hA30, 32'd3);
        n_cmp++;
        if (a_depth !== 3'd2) begin n_fail++; $display("FAIL nest_depth: got %0d expected 2", a_depth); end
        n_cmp++;
        if (a_rm0 !== 32'h30) begin n_fail++; $display("FAIL nest_rm0: got %h expected 30", a_rm0); end
        do_iret();
        n_cmp++;
        if (a_rm0 !== 32'h20) begin n_fail++; $display("FAIL nest_pop1_rm0: got %h expected 20", a_rm0); end
        n_cmp++;
        if (a_rm1 !== 32'hA20) begin n_fail++; $display("FAIL nest_pop1_rm1: got %h expected a20", a_rm1); end
        n_cmp++;
        if (a_rm2 !== 32'd2) begin n_fail++; $display("FAIL nest_pop1_rm2: got %h expected 2", a_rm2); end
        do_iret();
        n_cmp++;
        if (a_rm0 !== 32'h10) begin n_fail++; $display("FAIL nest_pop2_rm0: got %h expected 10", a_rm0); end
        n_cmp++;
        if (a_psw !== 32'd1) begin n_fail++; $display("FAIL nest_pop2_psw: got %h expected 1", a_psw); end
        n_cmp++;
        if (a_depth !== 3'd0) begin n_fail++; $display("FAIL nest_pop2_depth: got %0d expected 0", a_depth); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 3; i++) do_exc(32'h40 + 32'(i), 32'hA0 + 32'(i), 32'(i));
        n_cmp++;
        if (b_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", b_ovf); end
        do_exc(32'h44, 32'hA4, 32'd4);
        n_cmp++;
        if (b_depth !== 2'd2) begin n_fail++; $display("FAIL ovf_depth: got %0d expected 2", b_depth); end
        n_cmp++;
        if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", b_ovf); end
        n_cmp++;
        if (b_rm0 !== 32'h44) begin n_fail++; $display("FAIL ovf_rm0: got %h expected 44", b_rm0); end
        n_cmp++;
        if (a_depth !== 3'd3 || a_ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_deep_inst: got depth %0d ovf %b expected 3 0", a_depth, a_ovf);
        end
        do_iret();
        n_cmp++;
        if (b_rm0 !== 32'h42 || b_rm1 !== 32'hA2 || b_rm2 !== 32'd2 || b_psw !== 32'd1) begin
            n_fail++; $display("FAIL ovf_pop1: got %h %h %h %h expected 42 a2 2 1", b_rm0, b_rm1, b_rm2, b_psw);
        end
        n_cmp++;
        if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky1: got %b expected 1", b_ovf); end
        do_iret();
        n_cmp++;
        if (b_rm0 !== 32'h41 || b_rm1 !== 32'hA1 || b_rm2 !== 32'd1 || b_psw !== 32'd1) begin
            n_fail++; $display("FAIL ovf_pop2: got %h %h %h %h expected 41 a1 1 1", b_rm0, b_rm1, b_rm2, b_psw);
        end
        do_iret();
        n_cmp++;
        if (b_depth !== 2'd0 || b_psw !== 32'd0 || b_rm0 !== 32'h41) begin
            n_fail++; $display("FAIL ovf_underflow: got depth %0d psw %h rm0 %h expected 0 0 41", b_depth, b_psw, b_rm0);
        end
        n_cmp++;
        if (b_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky2: got %b expected 1", b_ovf); end
    endtask

    task automatic test_collisions();
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1, 3'd4, 32'hCAFE);
        n_cmp++;
        if (a_rm4 !== 32'hCAFE) begin n_fail++; $display("FAIL coll_write_rm4: got %h expected cafe", a_rm4); end
        do_exc(32'h50, 32'hB50, 32'd5);
        step(0, 1, 32'h60, 32'hB60, 32'd6, 0, 1, 3'd4, 32'h1234);
        n_cmp++;
        if (a_rm4 !== 32'hCAFE) begin n_fail++; $display("FAIL coll_exc_we_rm4: got %h expected cafe", a_rm4); end
        n_cmp++;
        if (a_rm0 !== 32'h60 || a_depth !== 3'd1) begin
            n_fail++; $display("FAIL coll_exc_we_load: got rm0 %h depth %0d expected 60 1", a_rm0, a_depth);
        end
        step(0, 0, 0, 0, 0, 1, 1, 3'd0, 32'd5);
        n_cmp++;
        if (a_rm0 !== 32'h50 || a_depth !== 3'd0) begin
            n_fail++; $display("FAIL coll_iret_we: got rm0 %h depth %0d expected 50 0", a_rm0, a_depth);
        end
        step(0, 0, 0, 0, 0, 0, 1, 3'd7, 32'hFFFF);
        rsel = 3'd7;
        #1;
        n_cmp++;
        if (a_rdata !== 32'd0) begin n_fail++; $display("FAIL coll_rsel7: got %h expected 0", a_rdata); end
        n_cmp++;
        if (a_rm0 !== 32'h50 || a_rm1 !== 32'hB50 || a_rm2 !== 32'd5 || a_psw !== 32'd1 || a_rm4 !== 32'hCAFE) begin
            n_fail++; $display("FAIL coll_wsel7: got %h %h %h %h %h expected 50 b50 5 1 cafe", a_rm0, a_rm1, a_rm2, a_psw, a_rm4);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 4; i++) do_exc(32'h70 + 32'(i), 32'hC0 + 32'(i), 32'(i));
        n_cmp++;
        if (a_depth !== 3'd3) begin n_fail++; $display("FAIL mid_depth_pre: got %0d expected 3", a_depth); end
        step(1, 1, 32'h99, 32'h99, 32'd9, 0, 0, 0, 0);
        n_cmp++;
        if (a_depth !== 3'd0 || a_psw !== 32'd0 || a_rm0 !== PC_INITIAL || a_rm1 !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset: got depth %0d psw %h rm0 %h rm1 %h expected 0 0 %h 0", a_depth, a_psw, a_rm0, a_rm1, PC_INITIAL);
        end
        n_cmp++;
        if (b_depth !== 2'd0 || b_ovf !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_shallow: got depth %0d ovf %b expected 0 0", b_depth, b_ovf);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_a, exp_b;
        logic        r, e, ir, w;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 99) < 35);
            ir = ($urandom_range(0, 99) < 35);
            w  = ($urandom_range(0, 99) < 40);
            step(r, e, $urandom, $urandom, 32'($urandom_range(1, 255)), ir, w,
                 3'($urandom_range(0, 7)), $urandom);
            rsel = 3'($urandom_range(0, 7));
            #1;
            exp_a = (rsel < 3'd5) ? m_rm[0][rsel] : 32'd0;
            exp_b = (rsel < 3'd5) ? m_rm[1][rsel] : 32'd0;
            n_cmp++;
            if (a_rdata !== exp_a) begin n_fail++; $display("FAIL rand_a_rdata[%0d]: got %h expected %h", n, a_rdata, exp_a); end
            n_cmp++;
            if (b_rdata !== exp_b) begin n_fail++; $display("FAIL rand_b_rdata[%0d]: got %h expected %h", n, b_rdata, exp_b); end
            n_cmp++;
            if (a_rm0 !== m_rm[0][0] || a_rm1 !== m_rm[0][1] || a_rm2 !== m_rm[0][2] || a_psw !== m_rm[0][3] || a_rm4 !== m_rm[0][4]) begin
                n_fail++; $display("FAIL rand_a_regs[%0d]: got %h %h %h %h %h expected %h %h %h %h %h", n,
                    a_rm0, a_rm1, a_rm2, a_psw, a_rm4, m_rm[0][0], m_rm[0][1], m_rm[0][2], m_rm[0][3], m_rm[0][4]);
            end
            n_cmp++;
            if (b_rm0 !== m_rm[1][0] || b_rm1 !== m_rm[1][1] || b_rm2 !== m_rm[1][2] || b_psw !== m_rm[1][3] || b_rm4 !== m_rm[1][4]) begin
                n_fail++; $display("FAIL rand_b_regs[%0d]: got %h %h %h %h %h expected %h %h %h %h %h", n,
                    b_rm0, b_rm1, b_rm2, b_psw, b_rm4, m_rm[1][0], m_rm[1][1], m_rm[1][2], m_rm[1][3], m_rm[1][4]);
            end
            n_cmp++;
            if (a_depth !== 3'(m_dep[0]) || a_ovf !== m_ovf[0]) begin
                n_fail++; $display("FAIL rand_a_stack[%0d]: got depth %0d ovf %b expected %0d %b", n, a_depth, a_ovf, m_dep[0], m_ovf[0]);
            end
            n_cmp++;
            if (b_depth !== 2'(m_dep[1]) || b_ovf !== m_ovf[1]) begin
                n_fail++; $display("FAIL rand_b_stack[%0d]: got depth %0d ovf %b expected %0d %b", n, b_depth, b_ovf, m_dep[1], m_ovf[1]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_user_mode();
        test_nesting();
        test_overflow();
        test_collisions();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
